// File: rtl/q_max_reader_if.sv
// Interface bundle for q_max_reader.
// It carries the request handshake, the Q-table read port and the result handshake.
// The slave modport is the reader's view.
// The master modport is the view of whoever drives requests, serves memory reads and takes results.
interface q_max_reader_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int STATE_WIDTH = 4,
  parameter int ACT_WIDTH   = 2,
  parameter int ADDR_WIDTH  = 6
);
  logic                   req_valid;
  logic                   req_ready;
  logic [STATE_WIDTH-1:0] req_state;
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_rd_addr;
  logic [DATA_WIDTH-1:0]  mem_rd_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [DATA_WIDTH-1:0]  q_max;
  logic [ACT_WIDTH-1:0]   best_action;
  logic                   res_err;

  modport slave (
    input  req_valid, req_state, mem_rd_data, res_ready,
    output req_ready, mem_rd_en, mem_rd_addr, res_valid, q_max, best_action, res_err
  );

  modport master (
    output req_valid, req_state, mem_rd_data, res_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, res_valid, q_max, best_action, res_err
  );
endinterface

// File: rtl/q_max_reader.sv
// q_max_reader: scans one state's Q-value row and returns its signed maximum and argmax.
// A request is accepted in IDLE.
// SCAN issues one read per action.
// LAST folds in the final read word.
// DONE holds the result until the consumer takes it.
// Ties keep the lowest action index, because a later action replaces the running max
// only when its value is strictly larger.
module q_max_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ACTIONS = 4,
  parameter int NUM_STATES  = 16,
  parameter int STATE_WIDTH = $clog2(NUM_STATES),
  parameter int ACT_WIDTH   = $clog2(NUM_ACTIONS),
  parameter int ADDR_WIDTH  = $clog2(NUM_STATES*NUM_ACTIONS)
) (
  input  logic           clk,
  input  logic           rst,
  q_max_reader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, LAST, DONE} state_t;

  localparam logic [ACT_WIDTH-1:0]   LAST_ACT    = ACT_WIDTH'(NUM_ACTIONS - 1);
  localparam logic [STATE_WIDTH:0]   STATE_LIMIT = (STATE_WIDTH+1)'(NUM_STATES);

  state_t                  state_reg;
  logic                    req_ready_reg;
  logic                    mem_rd_en_reg;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr_reg;
  logic                    res_valid_reg;
  logic [DATA_WIDTH-1:0]   q_max_reg;
  logic [ACT_WIDTH-1:0]    best_action_reg;
  logic                    res_err_reg;

  // Action index of the read issued this cycle.
  logic [ACT_WIDTH-1:0]    issue_act_reg;

  // A read was issued last cycle, so mem_rd_data is valid now.
  // pend_act_reg holds that read's action index.
  logic                    pend_reg;
  logic [ACT_WIDTH-1:0]    pend_act_reg;

  // Running maximum and argmax over the words received so far.
  logic [DATA_WIDTH-1:0]   run_max_reg;
  logic [ACT_WIDTH-1:0]    run_act_reg;

  logic                    state_oor;
  logic [ADDR_WIDTH-1:0]   row_base;
  logic                    take;
  logic [DATA_WIDTH-1:0]   max_next;
  logic [ACT_WIDTH-1:0]    act_next;

  // Range check and row base address of the incoming request.
  // Also the compare step of the data word returning this cycle.
  always_comb begin
    state_oor = ({1'b0, bus.req_state} >= STATE_LIMIT);
    row_base  = ADDR_WIDTH'(bus.req_state) * ADDR_WIDTH'(NUM_ACTIONS);
    take      = pend_reg &&
                ((pend_act_reg == '0) ||
                 ($signed(bus.mem_rd_data) > $signed(run_max_reg)));
    max_next  = take ? bus.mem_rd_data : run_max_reg;
    act_next  = take ? pend_act_reg    : run_act_reg;
  end

  // Control FSM with registered outputs, plus the compare pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      req_ready_reg   <= 1'b1;
      mem_rd_en_reg   <= 1'b0;
      mem_rd_addr_reg <= '0;
      res_valid_reg   <= 1'b0;
      q_max_reg       <= '0;
      best_action_reg <= '0;
      res_err_reg     <= 1'b0;
      issue_act_reg   <= '0;
      pend_reg        <= 1'b0;
      pend_act_reg    <= '0;
      run_max_reg     <= '0;
      run_act_reg     <= '0;
    end else begin
      // Each read's data arrives one cycle after the read is issued.
      pend_reg     <= mem_rd_en_reg;
      pend_act_reg <= issue_act_reg;
      if (pend_reg) begin
        run_max_reg <= max_next;
        run_act_reg <= act_next;
      end

      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_reg <= 1'b0;
            if (state_oor) begin
              // Out-of-range state: report an error result without touching memory.
              res_err_reg     <= 1'b1;
              q_max_reg       <= '0;
              best_action_reg <= '0;
              res_valid_reg   <= 1'b1;
              state_reg       <= DONE;
            end else begin
              res_err_reg     <= 1'b0;
              mem_rd_en_reg   <= 1'b1;
              mem_rd_addr_reg <= row_base;
              issue_act_reg   <= '0;
              state_reg       <= SCAN;
            end
          end
        end
        SCAN: begin
          if (issue_act_reg == LAST_ACT) begin
            mem_rd_en_reg <= 1'b0;
            state_reg     <= LAST;
          end else begin
            issue_act_reg   <= issue_act_reg + 1'b1;
            mem_rd_addr_reg <= mem_rd_addr_reg + 1'b1;
          end
        end
        LAST: begin
          // The final word is on mem_rd_data now, so take the result from the combinational step.
          q_max_reg       <= max_next;
          best_action_reg <= act_next;
          res_valid_reg   <= 1'b1;
          state_reg       <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_reg;
  assign bus.mem_rd_en   = mem_rd_en_reg;
  assign bus.mem_rd_addr = mem_rd_addr_reg;
  assign bus.res_valid   = res_valid_reg;
  assign bus.q_max       = q_max_reg;
  assign bus.best_action = best_action_reg;
  assign bus.res_err     = res_err_reg;

endmodule

// File: tb/tb_q_max_reader.sv
// Directed testbench for q_max_reader.
// It includes a synchronous-read Q-table model and a log of every read address and the clock edge that sampled it.
// The state port is one bit wider than the minimum, so that an out-of-range state can be driven.
module tb_q_max_reader;
  localparam int DW  = 32;
  localparam int NA  = 4;
  localparam int NS  = 16;
  localparam int SW  = 5;
  localparam int AW  = 2;
  localparam int ADW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] rd_data;
  int            rd_addr_q[$];
  int            rd_edge_q[$];

  q_max_reader_if #(.DATA_WIDTH(DW), .STATE_WIDTH(SW), .ACT_WIDTH(AW), .ADDR_WIDTH(ADW)) bus ();

  q_max_reader #(
    .DATA_WIDTH(DW), .NUM_ACTIONS(NA), .NUM_STATES(NS),
    .STATE_WIDTH(SW), .ACT_WIDTH(AW), .ADDR_WIDTH(ADW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd_data = rd_data;

  // Q-table model and read log.
  // A read logged with edge index E is the one sampled at the E-th rising edge.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      rd_addr_q.push_back(int'(bus.mem_rd_addr));
      rd_edge_q.push_back(cyc + 1);
      rd_data <= mem[bus.mem_rd_addr];
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and waits, for a bounded time, for res_valid.
  // ea is the accept edge; er is the edge after which res_valid is first seen.
  task automatic run_req(input int st, input logic rr, output int ea, output int er);
    rd_addr_q.delete();
    rd_edge_q.delete();
    check("req_ready_pre", 64'(bus.req_ready), 64'd1);
    bus.res_ready = rr;
    bus.req_state = SW'(st);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    ea = cyc;
    bus.req_valid = 1'b0;
    er = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) begin
        er = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("res_valid_seen", 64'(er >= 0), 64'd1);
    $display("txn state=%0d accept_edge=%0d res_edge=%0d q_max=0x%0h best=%0d err=%0d reads=%0d",
             st, ea, er, bus.q_max, bus.best_action, bus.res_err, rd_addr_q.size());
  endtask

  // Checks a completed in-range scan: the read sequence, the latency and the result.
  task automatic scan_check(input int ea, input int er, input int base,
                            input logic [DW-1:0] exp_max, input int exp_act);
    check("rd_count", 64'(rd_addr_q.size()), 64'(NA));
    for (int k = 0; k < NA && k < rd_addr_q.size(); k++) begin
      check($sformatf("rd_addr%0d", k), 64'(rd_addr_q[k]), 64'(base + k));
      check($sformatf("rd_edge%0d", k), 64'(rd_edge_q[k]), 64'(ea + 1 + k));
    end
    check("latency", 64'(er - ea + 1), 64'(NA + 2));
    check("q_max", 64'(bus.q_max), 64'(exp_max));
    check("best_action", 64'(bus.best_action), 64'(exp_act));
    check("res_err", 64'(bus.res_err), 64'd0);
  endtask

  // Waits out a handshake cycle, then checks that the DUT is back in IDLE.
  task automatic post_handshake(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_res_valid_after"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_req_ready_after"}, 64'(bus.req_ready), 64'd1);
  endtask

  // Bounds the whole run so that it always ends.
  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ea;
    int er;
    int seen;

    bus.req_valid = 1'b0;
    bus.req_state = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = DW'(i * 3 + 1);
    // State 3 row.
    mem[12] = 32'd5;         mem[13] = 32'hFFFF_FFFE; mem[14] = 32'd17;        mem[15] = 32'd9;
    // State 5 row: all negative, with a tie and the most negative value.
    mem[20] = 32'hFFFF_FFF9; mem[21] = 32'hFFFF_FFFD; mem[22] = 32'h8000_0000; mem[23] = 32'hFFFF_FFFD;
    // State 7 row: increasing values.
    mem[28] = 32'd10;        mem[29] = 32'd20;        mem[30] = 32'd30;        mem[31] = 32'd40;
    // State 2 row: used for the aborted scan.
    mem[8]  = 32'd100;       mem[9]  = 32'd200;       mem[10] = 32'd300;       mem[11] = 32'd400;
    // State 0 row: all equal.
    mem[0]  = 32'd1;         mem[1]  = 32'd1;         mem[2]  = 32'd1;         mem[3]  = 32'd1;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("rst_mem_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_q_max", 64'(bus.q_max), 64'd0);
    check("rst_best_action", 64'(bus.best_action), 64'd0);
    check("rst_res_err", 64'(bus.res_err), 64'd0);
    rd_addr_q.delete();
    rd_edge_q.delete();
    repeat (20) @(posedge clk);
    #1;
    check("idle_reads", 64'(rd_addr_q.size()), 64'd0);
    check("idle_req_ready", 64'(bus.req_ready), 64'd1);
    check("idle_res_valid", 64'(bus.res_valid), 64'd0);

    // State 3: basic scan.
    run_req(3, 1'b1, ea, er);
    scan_check(ea, er, 12, 32'd17, 2);
    post_handshake("s3");

    // State 5: negative values, a tie and the most negative value.
    run_req(5, 1'b1, ea, er);
    scan_check(ea, er, 20, 32'hFFFF_FFFD, 1);
    post_handshake("s5");

    // State 7: result held under back-pressure; a stray request is ignored.
    run_req(7, 1'b0, ea, er);
    scan_check(ea, er, 28, 32'd40, 3);
    rd_addr_q.delete();
    rd_edge_q.delete();
    for (int h = 0; h < 5; h++) begin
      if (h == 1) begin
        bus.req_state = SW'(2);
        bus.req_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check($sformatf("hold%0d_res_valid", h), 64'(bus.res_valid), 64'd1);
      check($sformatf("hold%0d_q_max", h), 64'(bus.q_max), 64'd40);
      check($sformatf("hold%0d_best", h), 64'(bus.best_action), 64'd3);
      check($sformatf("hold%0d_req_ready", h), 64'(bus.req_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    post_handshake("s7");
    check("s7_q_max_kept", 64'(bus.q_max), 64'd40);
    check("s7_best_kept", 64'(bus.best_action), 64'd3);
    repeat (3) @(posedge clk);
    #1;
    check("s7_no_stray_reads", 64'(rd_addr_q.size()), 64'd0);
    check("s7_no_stray_result", 64'(bus.res_valid), 64'd0);

    // Out-of-range state: immediate error result with no reads.
    run_req(16, 1'b1, ea, er);
    check("oor_reads", 64'(rd_addr_q.size()), 64'd0);
    check("oor_latency", 64'(er - ea + 1), 64'd1);
    check("oor_res_err", 64'(bus.res_err), 64'd1);
    check("oor_q_max", 64'(bus.q_max), 64'd0);
    check("oor_best", 64'(bus.best_action), 64'd0);
    post_handshake("oor");

    // Asynchronous reset after two of the four reads.
    rd_addr_q.delete();
    rd_edge_q.delete();
    bus.req_state = SW'(2);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    ea = cyc;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("arst_mem_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
    check("arst_req_ready", 64'(bus.req_ready), 64'd1);
    check("arst_res_valid", 64'(bus.res_valid), 64'd0);
    check("arst_q_max", 64'(bus.q_max), 64'd0);
    check("arst_res_err", 64'(bus.res_err), 64'd0);
    #2;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) seen++;
    end
    check("arst_no_result", 64'(seen), 64'd0);
    check("arst_reads", 64'(rd_addr_q.size()), 64'd2);
    $display("txn abort state=2 accept_edge=%0d reads_before_reset=%0d", ea, rd_addr_q.size());

    // State 0 after the abort: all values equal, so action 0 wins.
    run_req(0, 1'b1, ea, er);
    scan_check(ea, er, 0, 32'd1, 0);
    post_handshake("s0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
